// File: rtl/sched_update_reg.sv
// rtl/sched_update_reg.sv - register applying scheduled updates a programmed number of edges after acceptance
//
// Purpose: accepts "reg <= #delay value" style updates and applies each one
// req_delay clock edges after it is accepted. Up to DEPTH updates may be in
// flight at once. When several land on the same edge, the newest one wins.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  update request present
//   req_delay  edges from acceptance until apply (0 = apply at the accepting edge)
//   req_data   value to apply
//   req_ready  combinational: request is accepted this edge when req_valid & req_ready
//   value_out  current register value
//   upd_pulse  high for one cycle after any edge that wrote value_out
//   pending    number of occupied slots
//   overrun    sticky: a request was presented while req_ready was low
module sched_update_reg #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 4,
    parameter int               DLY_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [DLY_W-1:0]           req_delay,
    input  logic [WIDTH-1:0]           req_data,
    output logic                       req_ready,
    output logic [WIDTH-1:0]           value_out,
    output logic                       upd_pulse,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overrun
);

    localparam int RK_W = $clog2(DEPTH);
    localparam int PW   = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0][DLY_W-1:0]  slot_cnt;
    logic [DEPTH-1:0][WIDTH-1:0]  slot_data;
    logic [DEPTH-1:0][RK_W-1:0]   slot_rank;

    logic [DEPTH-1:0]             expiring;
    logic [DEPTH-1:0]             free_now;
    logic [DEPTH-1:0]             surviving;
    logic [DEPTH-1:0][RK_W-1:0]   new_rank;
    logic [RK_W-1:0]              alloc_idx;
    logic [RK_W-1:0]              best_rank;
    logic [WIDTH-1:0]             win_data;
    logic                         have_exp;
    logic                         accept;
    logic                         bypass;
    logic                         load;
    logic [RK_W-1:0]              lower_cnt;

    // A slot expiring at this edge counts as free, so a new request can
    // take it over at the very edge it is released.
    always_comb begin
        expiring  = '0;
        free_now  = '0;
        surviving = '0;
        for (int i = 0; i < DEPTH; i++) begin
            expiring[i]  = slot_valid[i] && (slot_cnt[i] == DLY_W'(1));
            free_now[i]  = !slot_valid[i] || expiring[i];
            surviving[i] = slot_valid[i] && !expiring[i];
        end
    end

    assign req_ready = (|free_now) || (req_delay == '0);
    assign accept    = req_valid && req_ready;
    assign bypass    = accept && (req_delay == '0);
    assign load      = accept && (req_delay != '0);

    // Lowest-index free slot.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (free_now[i]) alloc_idx = RK_W'(i);
        end
    end

    // Among expiring slots the lowest rank (most recently accepted) wins.
    always_comb begin
        have_exp  = 1'b0;
        best_rank = '0;
        win_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (expiring[i] && (!have_exp || slot_rank[i] < best_rank)) begin
                have_exp  = 1'b1;
                best_rank = slot_rank[i];
                win_data  = slot_data[i];
            end
        end
    end

    // On accept, surviving slots are renumbered 1..n in their existing
    // order behind the new rank-0 entry. Only relative order is meaningful,
    // and renumbering keeps every rank inside 0..DEPTH-1 however long the
    // stream of requests runs.
    always_comb begin
        new_rank  = '0;
        lower_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lower_cnt = RK_W'(1);
            for (int j = 0; j < DEPTH; j++) begin
                if (surviving[j] && (slot_rank[j] < slot_rank[i]))
                    lower_cnt = lower_cnt + RK_W'(1);
            end
            new_rank[i] = lower_cnt;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending + PW'(slot_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            slot_cnt   <= '0;
            slot_data  <= '0;
            slot_rank  <= '0;
            value_out  <= RESET_VAL;
            upd_pulse  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load && (alloc_idx == RK_W'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_cnt[i]   <= req_delay;
                    slot_data[i]  <= req_data;
                    slot_rank[i]  <= '0;
                end else if (expiring[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (slot_valid[i]) begin
                    slot_cnt[i] <= slot_cnt[i] - DLY_W'(1);
                    if (load) slot_rank[i] <= new_rank[i];
                end
            end

            // A bypass request is newer than anything already queued.
            if (bypass)
                value_out <= req_data;
            else if (have_exp)
                value_out <= win_data;

            upd_pulse <= bypass || have_exp;

            if (req_valid && !req_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sched_update_reg.sv
// tb/tb_sched_update_reg.sv - self-checking bench for sched_update_reg
module tb_sched_update_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_delay;
    logic [3:0] req_data;
    logic       req_ready;
    logic [3:0] value_out;
    logic       upd_pulse;
    logic [2:0] pending;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        logic [3:0] data;
    } ent_t;

    ent_t       sb[$];
    int         edge_n;
    logic [3:0] exp_val;
    logic       exp_ovr;

    sched_update_reg #(
        .WIDTH     (4),
        .DEPTH     (4),
        .DLY_W     (4),
        .RESET_VAL (4'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_delay (req_delay),
        .req_data  (req_data),
        .req_ready (req_ready),
        .value_out (value_out),
        .upd_pulse (upd_pulse),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one request (or idle) for the next edge, then check outputs after it.
    // Scoreboard entries carry the edge number at which they must land; entries
    // still ahead of the accepting edge are the occupied slots.
    task automatic step(input logic v, input logic [3:0] d, input logic [3:0] dat);
        int   occ;
        logic rdy;
        logic got_upd;
        req_valid = v;
        req_delay = d;
        req_data  = dat;
        #1;
        occ = 0;
        foreach (sb[k]) if (sb[k].due > edge_n + 1) occ++;
        rdy = (occ < 4) || (d == 4'd0);
        check("req_ready", req_ready, rdy);
        if (v && rdy) sb.push_back('{due: edge_n + 1 + int'(d), data: dat});
        if (v && !rdy) exp_ovr = 1'b1;
        @(posedge clk);
        edge_n++;
        #1;
        req_valid = 1'b0;
        got_upd = 1'b0;
        // Later pushes are newer, so the last entry due at this edge wins.
        for (int k = 0; k < sb.size();) begin
            if (sb[k].due == edge_n) begin
                exp_val = sb[k].data;
                got_upd = 1'b1;
                sb.delete(k);
            end else begin
                k++;
            end
        end
        check("value_out", value_out, exp_val);
        check("upd_pulse", upd_pulse, got_upd);
        check("pending", pending, sb.size());
        check("overrun", overrun, exp_ovr);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_delay = 4'd0;
        req_data  = 4'd0;
        edge_n    = 0;
        exp_val   = 4'd0;
        exp_ovr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_value", value_out, 4'd0);
        check("rst_pending", pending, 3'd0);
        check("rst_upd", upd_pulse, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // Long delay: lands exactly ten edges after acceptance.
        step(1'b1, 4'd10, 4'd5);
        repeat (11) step(1'b0, 4'd0, 4'd0);

        // Bypass.
        step(1'b1, 4'd0, 4'd3);
        step(1'b0, 4'd0, 4'd0);

        // Same-edge collision: B is newer and wins.
        step(1'b1, 4'd3, 4'd1);
        step(1'b1, 4'd2, 4'd2);
        repeat (3) step(1'b0, 4'd0, 4'd0);

        // Fill all slots at max delay, then a rejected and a bypass request.
        step(1'b1, 4'd15, 4'd1);
        step(1'b1, 4'd15, 4'd2);
        step(1'b1, 4'd15, 4'd4);
        step(1'b1, 4'd15, 4'd8);
        step(1'b1, 4'd5, 4'd6);
        step(1'b1, 4'd0, 4'd7);
        repeat (16) step(1'b0, 4'd0, 4'd0);

        // A slot frees and is reloaded on the same edge.
        step(1'b1, 4'd1, 4'hA);
        step(1'b1, 4'd3, 4'hB);
        repeat (3) step(1'b0, 4'd0, 4'd0);

        // Bypass beats an expiring slot.
        step(1'b1, 4'd2, 4'd6);
        step(1'b0, 4'd0, 4'd0);
        step(1'b1, 4'd0, 4'd9);
        step(1'b0, 4'd0, 4'd0);

        // Reset mid-count discards everything in flight.
        step(1'b1, 4'd4, 4'hC);
        step(1'b1, 4'd6, 4'hD);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_value", value_out, 4'd0);
        check("midrst_pending", pending, 3'd0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_upd", upd_pulse, 1'b0);
        sb.delete();
        exp_val = 4'd0;
        exp_ovr = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        edge_n++;
        #1;
        repeat (10) step(1'b0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
